// File: rtl/data_mem_responder.sv
// Variable-latency data-memory responder: req/resp handshake, address decode, wait states.
// Optional byte-lane store gating is enabled by defining DMEM_BYTE_LANE_EN.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = 32'h1001_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clockCPU,
    input  logic        reset,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [3:0]  iBe,
    input  logic        iRReady,
    output logic        oReady,
    output logic        oRValid,
    output logic [31:0] oRData,
    output logic        oErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        accept, commit;

    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be, lanes;
    logic        err;
    logic [AW-1:0] idx;
    logic [32:0] addr_ext, lo_bound, hi_bound;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        oReady  = 1'b0;
        oRValid = 1'b0;
        case (state)
            S_IDLE: begin
                oReady = 1'b1;
                if (iReq) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_n = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_RESP: begin
                oRValid = 1'b1;
                if (iRReady) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= iWe;
            addr_q  <= iAddr;
            wdata_q <= iWData;
            be_q    <= iBe;
        end
    end

    // With zero wait states the commit edge is also the accept edge, so take the live request.
    assign cur_we    = (state == S_IDLE) ? iWe    : we_q;
    assign cur_addr  = (state == S_IDLE) ? iAddr  : addr_q;
    assign cur_wdata = (state == S_IDLE) ? iWData : wdata_q;
    assign cur_be    = (state == S_IDLE) ? iBe    : be_q;

    assign addr_ext = {1'b0, cur_addr};
    assign lo_bound = {1'b0, BASE};
    assign hi_bound = lo_bound + (33'(DEPTH) << 2);
    assign err      = (addr_ext < lo_bound) | (addr_ext >= hi_bound) | (cur_addr[1:0] != 2'b00);
    // BASE is 4*DEPTH aligned, so the offset's index bits equal the address's own bits.
    assign idx      = cur_addr[AW+1:2];

`ifdef DMEM_BYTE_LANE_EN
    assign lanes = cur_be;
`else
    assign lanes = cur_be | 4'hF;
`endif

    always_ff @(posedge clockCPU) begin
        if (reset && commit && cur_we && !err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (lanes[k]) mem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            oRData <= '0;
            oErr   <= 1'b0;
        end else if (commit) begin
            oErr   <= err;
            oRData <= (!cur_we && !err) ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic
// against a word-array reference model; a second instance covers the zero-wait build.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        m_req = 0, m_we = 0, m_rready = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic        m_ready, m_rvalid, m_err;
    logic [31:0] m_rdata;

    logic        z_req = 0, z_we = 0, z_rready = 0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic [3:0]  z_be = '0;
    logic        z_ready, z_rvalid, z_err;
    logic [31:0] z_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] ref_mem [16];

    data_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(W)) dut (
        .clockCPU(clk), .reset(rst), .iReq(m_req), .iWe(m_we), .iAddr(m_addr),
        .iWData(m_wdata), .iBe(m_be), .iRReady(m_rready), .oReady(m_ready),
        .oRValid(m_rvalid), .oRData(m_rdata), .oErr(m_err)
    );

    data_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYCLES(0)) dut_z (
        .clockCPU(clk), .reset(rst), .iReq(z_req), .iWe(z_we), .iAddr(z_addr),
        .iWData(z_wdata), .iBe(z_be), .iRReady(z_rready), .oReady(z_ready),
        .oRValid(z_rvalid), .oRData(z_rdata), .oErr(z_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv, input logic [3:0] b);
        logic [31:0] r;
        bit on;
        r = old;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_BYTE_LANE_EN
            on = b[k];
`else
            on = 1'b1;
`endif
            if (on) r[8*k +: 8] = nv[8*k +: 8];
        end
        return r;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        longint x, lo, hi;
        x  = {32'd0, a};
        lo = {32'd0, BASE};
        hi = lo + 4 * longint'(DEPTH);
        return (x < lo) || (x >= hi) || (a % 4 != 0);
    endfunction

    // Issues one request, waits (bounded) for the response, holds it for 'hold' cycles, then accepts it.
    task automatic txn(input bit z, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input int unsigned hold,
                       output logic [31:0] rd, output logic er, output int unsigned lat);
        if (z) begin z_we = we; z_addr = a; z_wdata = d; z_be = b; z_req = 1'b1; end
        else   begin m_we = we; m_addr = a; m_wdata = d; m_be = b; m_req = 1'b1; end
        @(posedge clk); #1;
        m_req = 1'b0; z_req = 1'b0;
        lat = 1;
        while (!(z ? z_rvalid : m_rvalid) && lat < 40) begin @(posedge clk); #1; lat++; end
        rd = z ? z_rdata : m_rdata;
        er = z ? z_err : m_err;
        repeat (hold) begin @(posedge clk); #1; end
        if (z) z_rready = 1'b1; else m_rready = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0; z_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", m_ready); end
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", m_rvalid); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", m_err); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", m_ready); end
    endtask

    task automatic test_init();
        logic [31:0] rd, v;
        logic er;
        int unsigned lat;
        for (int k = 0; k < 16; k++) begin
            v = $urandom;
            txn(0, 1'b1, BASE + 32'(4 * k), v, 4'hF, 0, rd, er, lat);
            ref_mem[k] = v;
            checks++; if (er !== 1'b0 || lat != W + 1) begin errors++; $display("FAIL init_store%0d: err=%b lat=%0d want err=0 lat=%0d", k, er, lat, W + 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int unsigned lat;
        m_we = 1'b1; m_addr = BASE; m_wdata = 32'hDEAD_BEEF; m_be = 4'hF; m_req = 1'b1;
        @(posedge clk); #1;
        m_req = 1'b0;
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL mid_wait_ready: got %b want 0", m_ready); end
        #2 rst = 1'b0;
        #1;
        checks++; if (m_ready !== 1'b1 || m_rvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_state: ready=%b rvalid=%b want 1/0", m_ready, m_rvalid); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_resp: got rvalid=%b want 0", m_rvalid); end
        txn(0, 1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== ref_mem[0] || er !== 1'b0) begin errors++; $display("FAIL mid_prior_data: got %h err=%b want %h err=0", rd, er, ref_mem[0]); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic er;
        int unsigned lat;
        txn(0, 1'b1, BASE + 32'd4, 32'h1234_5678, 4'hF, 0, rd, er, lat);
        ref_mem[1] = 32'h1234_5678;
        checks++; if (lat != W + 1) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp: err=%b rdata=%h want 0/0", er, rd); end
        txn(0, 1'b0, BASE + 32'd4, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL raw_load: got %h err=%b want 12345678 err=0", rd, er); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, W + 1); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd;
        logic er;
        int unsigned lat;
        txn(0, 1'b1, BASE + 32'd8, 32'h1122_3344, 4'hF, 0, rd, er, lat);
        ref_mem[2] = 32'h1122_3344;
        txn(0, 1'b1, BASE + 32'd8, 32'hAABB_CCDD, 4'b0101, 0, rd, er, lat);
        ref_mem[2] = merge(ref_mem[2], 32'hAABB_CCDD, 4'b0101);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lane_store_err: got %b want 0", er); end
        txn(0, 1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== ref_mem[2]) begin errors++; $display("FAIL lane_merge: got %h want %h", rd, ref_mem[2]); end
        txn(0, 1'b1, BASE + 32'd12, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
        ref_mem[3] = merge(ref_mem[3], 32'hFFFF_FFFF, 4'b0000);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL be0_resp: err=%b rdata=%h want 0/0", er, rd); end
        txn(0, 1'b0, BASE + 32'd12, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== ref_mem[3]) begin errors++; $display("FAIL be0_data: got %h want %h", rd, ref_mem[3]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int unsigned lat;
        logic [31:0] bad [7];
        bad[0] = BASE + 32'd2;
        bad[1] = 32'h0040_0000;
        bad[2] = BASE + 32'(4 * DEPTH);
        bad[3] = BASE - 32'd4;
        bad[4] = 32'hFFFF_FFFC;
        bad[5] = BASE + 32'(4 * DEPTH);
        bad[6] = BASE + 32'd1;
        for (int i = 0; i < 7; i++) begin
            txn(0, (i >= 5), bad[i], 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
            checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_resp%0d addr=%h: err=%b rdata=%h want 1/0", i, bad[i], er, rd); end
        end
        txn(0, 1'b0, BASE, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== ref_mem[0]) begin errors++; $display("FAIL err_no_write: got %h want %h", rd, ref_mem[0]); end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic e;
        int unsigned lat;
        logic [31:0] rd;
        logic er;
        m_we = 1'b0; m_addr = BASE + 32'd4; m_be = 4'hF; m_req = 1'b1;
        @(posedge clk); #1;
        m_req = 1'b0;
        lat = 1;
        while (!m_rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL hold_latency: got %0d want %0d", lat, W + 1); end
        d = m_rdata; e = m_err;
        checks++; if (d !== ref_mem[1]) begin errors++; $display("FAIL hold_data: got %h want %h", d, ref_mem[1]); end
        m_we = 1'b1; m_addr = BASE + 32'd8; m_wdata = 32'h5A5A_0000 ^ 32'($urandom_range(0, 65535)); m_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (m_rvalid !== 1'b1 || m_rdata !== d || m_err !== e || m_ready !== 1'b0) begin
                errors++; $display("FAIL hold_stable%0d: rvalid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0", i, m_rvalid, m_rdata, m_err, m_ready, d, e);
            end
        end
        m_rready = 1'b1;
        @(posedge clk); #1;
        m_rready = 1'b0; m_req = 1'b0;
        checks++; if (m_ready !== 1'b1 || m_rvalid !== 1'b0) begin errors++; $display("FAIL hold_release: ready=%b rvalid=%b want 1/0", m_ready, m_rvalid); end
        @(posedge clk); #1;
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL hold_not_accepted: ready=%b want 1", m_ready); end
        txn(0, 1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, rd, er, lat);
        checks++; if (rd !== ref_mem[2]) begin errors++; $display("FAIL hold_no_write: got %h want %h", rd, ref_mem[2]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0, rd1;
        logic er0, er1;
        int unsigned lat0, lat1;
        int t0;
        t0 = cyc;
        txn(0, 1'b0, BASE + 32'd16, 32'h0, 4'h0, 0, rd0, er0, lat0);
        txn(0, 1'b0, BASE + 32'd20, 32'h0, 4'h0, 0, rd1, er1, lat1);
        checks++; if (cyc - t0 != 2 * (W + 2)) begin errors++; $display("FAIL b2b_cycles: got %0d want %0d", cyc - t0, 2 * (W + 2)); end
        checks++; if (rd0 !== ref_mem[4] || rd1 !== ref_mem[5]) begin errors++; $display("FAIL b2b_data: got %h %h want %h %h", rd0, rd1, ref_mem[4], ref_mem[5]); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_d;
        logic [3:0] b;
        logic we, er, e;
        int unsigned lat, k, sel;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            k   = $urandom_range(0, 15);
            if (sel <= 6)      a = BASE + 32'(4 * k);
            else if (sel == 7) a = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(0, 32'h1000_FFFF));
            else               a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            b  = 4'($urandom);
            e  = exp_err(a);
            exp_d = 32'h0;
            if (!e && we)  ref_mem[k] = merge(ref_mem[k], d, b);
            if (!e && !we) exp_d = ref_mem[k];
            txn(0, we, a, d, b, $urandom_range(0, 3), rd, er, lat);
            checks++; if (er !== e || rd !== exp_d || lat != W + 1) begin
                errors++; $display("FAIL rand%0d we=%b addr=%h: err=%b rdata=%h lat=%0d want %b/%h/%0d", n, we, a, er, rd, lat, e, exp_d, W + 1);
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd0, rd1;
        logic er;
        int unsigned lat0, lat1;
        int t0;
        txn(1, 1'b1, BASE, 32'hA5A5_0001, 4'hF, 0, rd0, er, lat0);
        checks++; if (lat0 != 1 || er !== 1'b0) begin errors++; $display("FAIL zw_store: lat=%0d err=%b want 1/0", lat0, er); end
        txn(1, 1'b1, BASE + 32'd4, 32'h5A5A_0002, 4'hF, 0, rd0, er, lat0);
        t0 = cyc;
        txn(1, 1'b0, BASE, 32'h0, 4'h0, 0, rd0, er, lat0);
        txn(1, 1'b0, BASE + 32'd4, 32'h0, 4'h0, 0, rd1, er, lat1);
        checks++; if (lat0 != 1 || lat1 != 1) begin errors++; $display("FAIL zw_latency: got %0d %0d want 1 1", lat0, lat1); end
        checks++; if (cyc - t0 != 4) begin errors++; $display("FAIL zw_b2b_cycles: got %0d want 4", cyc - t0); end
        checks++; if (rd0 !== 32'hA5A5_0001 || rd1 !== 32'h5A5A_0002) begin errors++; $display("FAIL zw_data: got %h %h want a5a50001 5a5a0002", rd0, rd1); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_reset_mid();
        test_store_load();
        test_byte_lane();
        test_errors();
        test_hold();
        test_back_to_back();
        test_random();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
